ram_loader: RTL

//   Upstream program loader for the RAM stage. On start, it accepts (1<<(N/2)) bytes over a valid/ready byte stream.
//   It writes them to RAM addresses 0..(1<<(N/2))-1 by driving the RAM's memory_address/data_in/store inputs.

---
 rtl/ram_loader_if.sv | 21 ++
 rtl/ram_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_loader_if.sv
// Byte-stream handshake between the program source and ram_loader.
// The source drives byte_in/byte_valid; the loader answers with byte_ready.
interface ram_loader_if #(
  parameter int N = 8
) ();
  logic [N-1:0] byte_in;
  logic         byte_valid;
  logic         byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/ram_loader.sv
// Program loader in front of the RAM: streams LOAD_WORDS bytes into addresses 0.. while halting the CPU.
// Optional trailing checksum byte is enabled with `define RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int N          = 8,
  parameter int LOAD_WORDS = 1 << (N / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  ram_loader_if.slave      stream,
  input  logic [N/2-1:0]   cpu_addr,
  input  logic [N-1:0]     cpu_data,
  input  logic             cpu_store,
  output logic [N/2-1:0]   memory_address,
  output logic [N-1:0]     data_out,
  output logic             store,
  output logic             cpu_halt,
  output logic             busy,
  output logic             done,
  output logic [N/2:0]     words_written,
  output logic             checksum_ok
);

  localparam int A = N / 2;
  localparam logic [A-1:0] LAST_ADDR = A'(LOAD_WORDS - 1);
  localparam logic [A-1:0] ONE_ADDR  = 1;
  localparam logic [A:0]   ONE_WORD  = 1;

`ifdef RAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, FINISH, CHECK} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_e;
`endif

  state_e         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [N-1:0]   data_q, data_d;
  logic [A:0]     words_q, words_d;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [N-1:0]   sum_q, sum_d;
  logic           chk_q, chk_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      chk_q   <= chk_d;
`endif
    end
  end

  // Each byte costs one LOAD (handshake) cycle and one WRITE (commit) cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   if (stream.byte_valid) state_d = WRITE;
      WRITE: begin
        if (addr_q != LAST_ADDR) state_d = LOAD;
`ifdef RAM_LOADER_CHECKSUM_EN
        else                     state_d = CHECK;
`else
        else                     state_d = FINISH;
`endif
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CHECK:  if (stream.byte_valid) state_d = FINISH;
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          words_d = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          chk_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (stream.byte_valid) data_d = stream.byte_in;
      end
      WRITE: begin
        words_d = words_q + ONE_WORD;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + data_q;
`endif
        // Counter parks on the last address instead of wrapping.
        if (addr_q != LAST_ADDR) addr_d = addr_q + ONE_ADDR;
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (stream.byte_valid) chk_d = (sum_q == stream.byte_in);
      end
`endif
      default: ;
    endcase
  end

  // Outside IDLE the CPU side is fully disconnected from the RAM port.
  always_comb begin
    stream.byte_ready = 1'b0;
    memory_address    = addr_q;
    data_out          = data_q;
    store             = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state_q)
      IDLE: begin
        memory_address = cpu_addr;
        data_out       = cpu_data;
        store          = cpu_store;
        busy           = 1'b0;
      end
      LOAD:   stream.byte_ready = 1'b1;
      WRITE:  store = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
      CHECK:  stream.byte_ready = 1'b1;
`endif
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_halt      = busy;
  assign words_written = words_q;

`ifdef RAM_LOADER_CHECKSUM_EN
  assign checksum_ok = chk_q;
`else
  assign checksum_ok = 1'b1;
`endif

endmodule
